// File: rtl/multiplicador_divisor_pkg.sv
// Shared definitions for the iterative MIPS multiply/divide unit:
// operation codes, FSM states and the default operand width.
package multiplicador_divisor_pkg;

  localparam int LARGURA_PADRAO = 32;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    CALC   = 2'd1,
    AJUSTE = 2'd2,
    FIM    = 2'd3
  } estado_t;

endpackage

// File: rtl/multiplicador_divisor_passo.sv
// One combinational iteration: add-shift for multiply,
// trial-subtract (restoring) for divide.
module md_passo_iterativo
  import multiplicador_divisor_pkg::*;
#(
  parameter int LARGURA = LARGURA_PADRAO
) (
  input  logic               modo_div,
  input  logic [LARGURA:0]   acc,
  input  logic [LARGURA-1:0] quo,
  input  logic [LARGURA-1:0] oper,
  output logic [LARGURA:0]   acc_prox,
  output logic [LARGURA-1:0] quo_prox
);

  logic [LARGURA:0]   soma;
  logic [LARGURA:0]   desloc;
  logic [LARGURA+1:0] dif;

  always_comb begin
    soma     = quo[0] ? acc + {1'b0, oper} : acc;
    desloc   = {acc[LARGURA-1:0], quo[LARGURA-1]};
    dif      = {1'b0, desloc} - {2'b00, oper};
    acc_prox = {1'b0, soma[LARGURA:1]};
    quo_prox = {soma[0], quo[LARGURA-1:1]};
    if (modo_div) begin
      // negative trial result means restore the shifted remainder
      if (dif[LARGURA+1]) begin
        acc_prox = desloc;
        quo_prox = {quo[LARGURA-2:0], 1'b0};
      end else begin
        acc_prox = dif[LARGURA:0];
        quo_prox = {quo[LARGURA-2:0], 1'b1};
      end
    end
  end

endmodule

// File: rtl/multiplicador_divisor.sv
// Iterative MIPS MULT/MULTU/DIV/DIVU/MTHI/MTLO unit with HI/LO
// registers and a start/busy/done handshake.
module multiplicador_divisor
  import multiplicador_divisor_pkg::*;
#(
  parameter int LARGURA = LARGURA_PADRAO
) (
  input  logic               md_in_clk,
  input  logic               md_in_rst_n,
  input  logic               md_in_start,
  input  logic [2:0]         md_in_op,
  input  logic [LARGURA-1:0] md_in_rs,
  input  logic [LARGURA-1:0] md_in_rt,
  input  logic               md_in_cancel,
  output logic               md_out_busy,
  output logic               md_out_done,
  output logic               md_out_div_zero,
  output logic [LARGURA-1:0] md_out_hi,
  output logic [LARGURA-1:0] md_out_lo
);

  localparam int CW = (LARGURA > 1) ? $clog2(LARGURA) : 1;
  localparam logic [CW-1:0] ULTIMO = CW'(LARGURA - 1);

  estado_t              estado_q, estado_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [LARGURA:0]     acc_q, acc_d;
  logic [LARGURA-1:0]   quo_q, quo_d;
  logic [LARGURA-1:0]   oper_q, oper_d;
  logic                 modo_div_q, modo_div_d;
  logic                 neg_hi_q, neg_hi_d;
  logic                 neg_lo_q, neg_lo_d;
  logic                 dz_q, dz_d;
  logic [LARGURA-1:0]   hi_q, hi_d;
  logic [LARGURA-1:0]   lo_q, lo_d;
  logic                 done_q, done_d;
  logic                 dzp_q, dzp_d;

  logic [LARGURA:0]     acc_passo;
  logic [LARGURA-1:0]   quo_passo;
  logic                 sa, sb, eh_div, op_md, rt_zero;
  logic [LARGURA-1:0]   mag_rs, mag_rt;
  logic [2*LARGURA-1:0] produto, prod_neg;

  md_passo_iterativo #(.LARGURA(LARGURA)) u_passo (
    .modo_div (modo_div_q),
    .acc      (acc_q),
    .quo      (quo_q),
    .oper     (oper_q),
    .acc_prox (acc_passo),
    .quo_prox (quo_passo)
  );

  always_comb begin
    estado_d   = estado_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    quo_d      = quo_q;
    oper_d     = oper_q;
    modo_div_d = modo_div_q;
    neg_hi_d   = neg_hi_q;
    neg_lo_d   = neg_lo_q;
    dz_d       = dz_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    dzp_d      = 1'b0;

    sa       = ~md_in_op[0] & md_in_rs[LARGURA-1];
    sb       = ~md_in_op[0] & md_in_rt[LARGURA-1];
    mag_rs   = sa ? -md_in_rs : md_in_rs;
    mag_rt   = sb ? -md_in_rt : md_in_rt;
    eh_div   = md_in_op[1];
    op_md    = ~md_in_op[2];
    rt_zero  = (md_in_rt == '0);
    produto  = {acc_q[LARGURA-1:0], quo_q};
    prod_neg = -produto;

    unique case (estado_q)
      OCIOSO: begin
        if (md_in_start) begin
          unique case (1'b1)
            op_md: begin
              estado_d   = CALC;
              cnt_d      = '0;
              acc_d      = '0;
              modo_div_d = eh_div;
              quo_d      = eh_div ? mag_rs : mag_rt;
              oper_d     = eh_div ? mag_rt : mag_rs;
              // divide-by-zero keeps an all-ones quotient
              neg_lo_d   = (sa ^ sb) & ~(eh_div & rt_zero);
              neg_hi_d   = eh_div ? sa : (sa ^ sb);
              dz_d       = eh_div & rt_zero;
            end
            (md_in_op == OP_MTHI): hi_d = md_in_rs;
            (md_in_op == OP_MTLO): lo_d = md_in_rs;
            default: ;
          endcase
        end
      end
      CALC: begin
        if (md_in_cancel) begin
          estado_d = OCIOSO;
        end else begin
          acc_d = acc_passo;
          quo_d = quo_passo;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == ULTIMO) estado_d = AJUSTE;
        end
      end
      AJUSTE: begin
        if (md_in_cancel) begin
          estado_d = OCIOSO;
        end else begin
          estado_d = FIM;
          if (modo_div_q) begin
            if (neg_lo_q) quo_d = -quo_q;
            if (neg_hi_q) acc_d = {1'b0, -acc_q[LARGURA-1:0]};
          end else if (neg_lo_q) begin
            acc_d = {1'b0, prod_neg[2*LARGURA-1:LARGURA]};
            quo_d = prod_neg[LARGURA-1:0];
          end
        end
      end
      FIM: begin
        estado_d = OCIOSO;
        hi_d     = acc_q[LARGURA-1:0];
        lo_d     = quo_q;
        done_d   = 1'b1;
        dzp_d    = dz_q;
      end
      default: estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge md_in_clk or negedge md_in_rst_n) begin
    if (!md_in_rst_n) begin
      estado_q   <= OCIOSO;
      cnt_q      <= '0;
      acc_q      <= '0;
      quo_q      <= '0;
      oper_q     <= '0;
      modo_div_q <= 1'b0;
      neg_hi_q   <= 1'b0;
      neg_lo_q   <= 1'b0;
      dz_q       <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      dzp_q      <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      quo_q      <= quo_d;
      oper_q     <= oper_d;
      modo_div_q <= modo_div_d;
      neg_hi_q   <= neg_hi_d;
      neg_lo_q   <= neg_lo_d;
      dz_q       <= dz_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      dzp_q      <= dzp_d;
    end
  end

  assign md_out_busy     = (estado_q != OCIOSO);
  assign md_out_done     = done_q;
  assign md_out_div_zero = dzp_q;
  assign md_out_hi       = hi_q;
  assign md_out_lo       = lo_q;

endmodule
